// File: rtl/fir_xifu_pkg.sv
// Shared types, encodings and field helpers for the XIFU FIR coprocessor.
// Used by the decode stage, its issue queue and the testbench.
package fir_xifu_pkg;

  localparam int X_ID_W = 4;

  localparam logic [6:0] INSTR_OPCODE          = 7'h0B;
  localparam logic [2:0] INSTR_XFIRLW_FUNCT3   = 3'h0;
  localparam logic [2:0] INSTR_XFIRSW_FUNCT3   = 3'h1;
  localparam logic [2:0] INSTR_XFIRDOTP_FUNCT3 = 3'h2;

  typedef struct packed {
    logic [31:0]       instr;
    logic [1:0][31:0]  rs;
    logic [X_ID_W-1:0] id;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic loadstore;
  } x_issue_resp_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] result;
  } wb_fwd_t;

  typedef struct packed {
    logic              issue;
    logic [X_ID_W-1:0] id;
  } id2ctrl_t;

  typedef struct packed {
    logic [X_ID_W-1:0] id;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       base;
    logic [31:0]       op2;
    logic [31:0]       offset;
    logic [4:0]        shamt;
    logic              writeback;
    logic              loadstore;
  } id2ex_t;

  function automatic logic [11:0] xifu_get_immediate_I(
    input logic [31:0] instr
  );
    return instr[31:20];
  endfunction

  function automatic logic [11:0] xifu_get_immediate_S(
    input logic [31:0] instr
  );
    return {instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [4:0] xifu_get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] xifu_get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [4:0] xifu_get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  // One forwarding source hits a register when it writes that register.
  function automatic logic fwd_sel(input wb_fwd_t f, input logic [4:0] rs);
    return f.we && (f.rd == rs);
  endfunction

endpackage

// File: rtl/fir_xifu_id_q_if.sv
// XIF issue channel between the core and the XIFU decode stage.
// master = core side, slave = coprocessor side.
interface fir_xifu_id_q_if
  import fir_xifu_pkg::*;
;
  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;

  modport master (
    output issue_valid,
    output issue_req,
    input  issue_ready,
    input  issue_resp
  );

  modport slave (
    input  issue_valid,
    input  issue_req,
    output issue_ready,
    output issue_resp
  );
endinterface

// File: rtl/fir_xifu_id_decode.sv
// Combinational decoder for xfirlw / xfirsw / xfirdotp.
// Produces the issue response and the EX payload (base = rs[0]).
module fir_xifu_id_decode
  import fir_xifu_pkg::*;
(
  input  x_issue_req_t  req,
  output x_issue_resp_t resp,
  output id2ex_t        payload,
  output logic          valid
);
  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [2:0]  f3;
  logic        is_op;

  assign imm_i = xifu_get_immediate_I(req.instr);
  assign imm_s = xifu_get_immediate_S(req.instr);
  assign f3    = req.instr[14:12];
  assign is_op = (req.instr[6:0] == INSTR_OPCODE);

  // Field extraction and per-funct3 response/offset selection.
  always_comb begin
    resp            = '0;
    valid           = 1'b0;
    payload         = '0;
    payload.id      = req.id;
    payload.rs1     = xifu_get_rs1(req.instr);
    payload.rs2     = xifu_get_rs2(req.instr);
    payload.rd      = xifu_get_rd(req.instr);
    payload.base    = req.rs[0];
    payload.op2     = req.rs[1];
    unique case (1'b1)
      is_op && f3 == INSTR_XFIRLW_FUNCT3: begin
        valid          = 1'b1;
        resp           = '{accept: 1'b1, writeback: 1'b1,
                           loadstore: 1'b1};
        payload.offset = {{20{imm_i[11]}}, imm_i};
      end
      is_op && f3 == INSTR_XFIRSW_FUNCT3: begin
        valid          = 1'b1;
        resp           = '{accept: 1'b1, writeback: 1'b1,
                           loadstore: 1'b1};
        payload.offset = {{18{imm_s[11]}}, imm_s[11:5], 7'b0};
        payload.shamt  = imm_s[4:0];
      end
      is_op && f3 == INSTR_XFIRDOTP_FUNCT3: begin
        valid          = 1'b1;
        resp           = '{accept: 1'b1, writeback: 1'b0,
                           loadstore: 1'b0};
      end
      default: ;
    endcase
    payload.writeback = resp.writeback;
    payload.loadstore = resp.loadstore;
  end

endmodule

// File: rtl/fir_xifu_id_q.sv
// XIFU decode stage with a DEPTH-entry issue queue and base snooping.
// Optional perf counters when FIR_XIFU_ID_PERF_EN is defined.
module fir_xifu_id_q
  import fir_xifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NFWD  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  fir_xifu_id_q_if.slave     xif_issue_i,
  input  wb_fwd_t [NFWD-1:0] wb_fwd_i,
  output id2ctrl_t           id2ctrl_o,
  output logic               ex_valid_o,
  output id2ex_t             id2ex_o,
  input  logic               ex_ready_i
`ifdef FIR_XIFU_ID_PERF_EN
  ,
  output logic [2:0][31:0]   perf_o
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  id2ex_t        q [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  x_issue_resp_t dec_resp;
  id2ex_t        dec_pl;
  id2ex_t        push_pl;
  logic          dec_ok;
  logic          push;
  logic          pop;
  logic [32:0]   push_fwd;
  logic [32:0]   slot_fwd [DEPTH];
  logic [DEPTH-1:0] slot_vld;

  // Lowest-index matching source wins: scan downward, overwrite.
  function automatic logic [32:0] fwd_pick(
    input logic [4:0]         rs,
    input wb_fwd_t [NFWD-1:0] f
  );
    logic [32:0] r;
    r = '0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_sel(f[i], rs)) r = {1'b1, f[i].result};
    end
    return r;
  endfunction

  fir_xifu_id_decode u_decode (
    .req     (xif_issue_i.issue_req),
    .resp    (dec_resp),
    .payload (dec_pl),
    .valid   (dec_ok)
  );

  assign xif_issue_i.issue_resp  = dec_resp;
  assign xif_issue_i.issue_ready = (count < CW'(DEPTH));
  assign ex_valid_o = (count != '0);
  assign pop        = ex_valid_o & ex_ready_i;
  assign push       = xif_issue_i.issue_valid
                    & xif_issue_i.issue_ready
                    & dec_ok & ~clear_i & ~rst_i;

  // Scoreboard notification for each enqueued instruction.
  always_comb begin
    id2ctrl_o = '0;
    if (push) begin
      id2ctrl_o.issue = 1'b1;
      id2ctrl_o.id    = xif_issue_i.issue_req.id;
    end
  end

  // Forwarding for the incoming entry and snooping for stored ones.
  always_comb begin
    push_fwd = fwd_pick(dec_pl.rs1, wb_fwd_i);
    push_pl  = dec_pl;
    if (push_fwd[32]) push_pl.base = push_fwd[31:0];
    for (int j = 0; j < DEPTH; j++) begin
      slot_fwd[j] = fwd_pick(q[j].rs1, wb_fwd_i);
      slot_vld[j] = CW'(PW'(PW'(j) - rptr)) < count;
    end
  end

  // Head entry with this cycle's snoop result applied.
  always_comb begin
    id2ex_o = '0;
    if (ex_valid_o) begin
      id2ex_o = q[rptr];
      if (slot_fwd[rptr][32]) id2ex_o.base = slot_fwd[rptr][31:0];
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) q[j] <= '0;
    end else if (clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) q[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if (slot_vld[j] && slot_fwd[j][32]) begin
          q[j].base <= slot_fwd[j][31:0];
        end
      end
      if (pop) begin
        q[rptr] <= '0;
        rptr    <= rptr + PW'(1);
      end
      if (push) begin
        q[wptr] <= push_pl;
        wptr    <= wptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef FIR_XIFU_ID_PERF_EN
  logic [31:0] cnt_acc;
  logic [31:0] cnt_rej;
  logic [31:0] cnt_stall;
  logic        ev_rej;
  logic        ev_stall;

  assign ev_rej   = xif_issue_i.issue_valid & ~dec_resp.accept;
  assign ev_stall = xif_issue_i.issue_valid & ~xif_issue_i.issue_ready;
  assign perf_o   = {cnt_acc, cnt_rej, cnt_stall};

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_acc   <= '0;
      cnt_rej   <= '0;
      cnt_stall <= '0;
    end else if (clear_i) begin
      cnt_acc   <= '0;
      cnt_rej   <= '0;
      cnt_stall <= '0;
    end else begin
      if (push && cnt_acc != '1) cnt_acc <= cnt_acc + 32'd1;
      if (ev_rej && cnt_rej != '1) cnt_rej <= cnt_rej + 32'd1;
      if (ev_stall && cnt_stall != '1) begin
        cnt_stall <= cnt_stall + 32'd1;
      end
    end
  end
`endif

endmodule
